// File: rtl/median_window_gen.sv
// median_window_gen: raster-scan 3x3 window generator feeding a median filter.
// Optional feature: define MF_SOF_RESYNC_EN to let an accepted sof pixel restart framing at (0,0).
module median_window_gen #(
    parameter int DW    = 8,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int CW    = 10,
    parameter int RW    = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DW-1:0]   pix_in,
    input  logic            pix_valid,
    input  logic            sof,
    output logic [9*DW-1:0] win_out,
    output logic            win_valid,
    output logic [CW-1:0]   win_col,
    output logic [RW-1:0]   win_row,
    output logic            frame_done
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]      state, state_n;
    logic [CW-1:0]   col, cc, col_n;
    logic [RW-1:0]   row, cr, row_n;
    logic [DW-1:0]   lb1 [0:IMG_W-1];
    logic [DW-1:0]   lb2 [0:IMG_W-1];
    logic [6*DW-1:0] sr;
    logic [9*DW-1:0] nxt;
    logic            resync, col_wrap, row_wrap, win_ok;

`ifdef MF_SOF_RESYNC_EN
    assign resync = sof;
`else
    assign resync = sof & 1'b0;
`endif

    // Effective pixel position, next counters/state and the window this pixel completes
    always_comb begin
        cc       = resync ? '0 : col;
        cr       = resync ? '0 : row;
        col_wrap = cc == CW'(IMG_W - 1);
        row_wrap = col_wrap && cr == RW'(IMG_H - 1);
        col_n    = col_wrap ? '0 : cc + 1'b1;
        row_n    = !col_wrap ? cr : row_wrap ? '0 : cr + 1'b1;
        win_ok   = state == RUN && cc >= CW'(2);
        state_n  = (resync || state == IDLE) ? FILL :
                   (state == FILL && col_wrap && cr == RW'(1)) ? RUN :
                   (state == RUN && row_wrap) ? FILL : state;
        nxt      = {pix_in, sr[DW*5 +: DW], sr[DW*4 +: DW],
                    lb1[cc], sr[DW*3 +: DW], sr[DW*2 +: DW],
                    lb2[cc], sr[DW*1 +: DW], sr[DW*0 +: DW]};
    end

    // Counters, FSM and registered window outputs; idle cycles hold everything but the pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            state      <= IDLE;
            win_out    <= '0;
            win_valid  <= 1'b0;
            win_col    <= '0;
            win_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= pix_valid && win_ok;
            frame_done <= pix_valid && row_wrap;
            if (pix_valid) begin
                col   <= col_n;
                row   <= row_n;
                state <= state_n;
                if (win_ok) begin
                    win_out <= nxt;
                    win_col <= cc - 1'b1;
                    win_row <= cr - 1'b1;
                end
            end
        end
    end

    // Line buffers and column shift register; the reads above see pre-write contents
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb1[cc] <= pix_in;
            lb2[cc] <= lb1[cc];
            sr      <= {nxt[DW*8 +: DW], nxt[DW*7 +: DW], nxt[DW*5 +: DW],
                        nxt[DW*4 +: DW], nxt[DW*2 +: DW], nxt[DW*1 +: DW]};
        end
    end
endmodule

// File: tb/tb_median_window_gen.sv
// tb_median_window_gen: randomized bench for median_window_gen against a frame-image model.
module tb_median_window_gen;
    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int CW = 2;
    localparam int RW = 2;
`ifdef MF_SOF_RESYNC_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            pix_valid = 1'b0;
    logic            sof = 1'b0;
    logic [DW-1:0]   pix_in = '0;
    logic [9*DW-1:0] win_out;
    logic            win_valid, frame_done;
    logic [CW-1:0]   win_col;
    logic [RW-1:0]   win_row;

    int errors = 0;
    int checks = 0;
    int mr = 0;
    int mc = 0;
    int n_win = 0;
    int n_fd = 0;
    int m_win = 0;
    int m_fd = 0;
    int last_row = 0;
    int last_col = 0;
    logic [DW-1:0]   img [H][W];
    logic [9*DW-1:0] last_win = '0;
    logic [9*DW-1:0] first_win;

    median_window_gen #(.DW(DW), .IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
        .clk(clk), .reset(reset), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .win_out(win_out), .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_hold(input string tag);
        check({tag, "_win"}, 72'(win_out), 72'(last_win));
        check({tag, "_row"}, 72'(win_row), 72'(last_row));
        check({tag, "_col"}, 72'(win_col), 72'(last_col));
    endtask

    task automatic push(input logic [DW-1:0] p, input logic s);
        logic [9*DW-1:0] w;
        bit v, fd;
        w = '0;
        @(negedge clk);
        pix_in = p;
        sof = s;
        pix_valid = 1'b1;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof = 1'b0;
        if (RS && s) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = p;
        v = mr >= 2 && mc >= 2;
        fd = mr == H - 1 && mc == W - 1;
        if (v) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[DW*(3*i+j) +: DW] = img[mr-2+i][mc-2+j];
            last_win = w;
            last_row = mr - 1;
            last_col = mc - 1;
            m_win++;
        end
        if (fd) m_fd++;
        check("win_valid", 72'(win_valid), 72'(v));
        check("frame_done", 72'(frame_done), 72'(fd));
        check_hold("out");
        n_win += int'(win_valid);
        n_fd += int'(frame_done);
        mc++;
        if (mc == W) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end
    endtask

    task automatic gap();
        @(negedge clk);
        @(posedge clk);
        #1;
        check("idle_valid", 72'(win_valid), 72'(0));
        check("idle_fd", 72'(frame_done), 72'(0));
        check_hold("idle");
    endtask

    task automatic run(input int n, input int g, input bit ramp, input bit rsof);
        for (int k = 0; k < n; k++) begin
            push(ramp ? DW'(4 * mr + mc) : DW'($urandom), rsof && $urandom_range(0, 11) == 0);
            repeat (g >= 0 ? g : int'($urandom_range(0, 2))) gap();
        end
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_win", 72'(win_out), 72'(0));
        check("rst_valid", 72'(win_valid), 72'(0));
        check("rst_col", 72'(win_col), 72'(0));
        check("rst_row", 72'(win_row), 72'(0));
        check("rst_fd", 72'(frame_done), 72'(0));
        mr = 0;
        mc = 0;
        last_win = '0;
        last_row = 0;
        last_col = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_counts();
        n_win = 0;
        n_fd = 0;
        m_win = 0;
        m_fd = 0;
    endtask

    initial begin
        first_win = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        do_reset();
        // Ramp frame back-to-back
        clear_counts();
        run(11, 0, 1'b1, 1'b0);
        check("first_win", 72'(win_out), 72'(first_win));
        check("first_row", 72'(win_row), 72'(1));
        check("first_col", 72'(win_col), 72'(1));
        run(5, 0, 1'b1, 1'b0);
        check("f1_wins", 72'(n_win), 72'(4));
        check("f1_fd", 72'(n_fd), 72'(1));
        // Ramp frame with a gap on every other cycle
        clear_counts();
        run(16, 1, 1'b1, 1'b0);
        check("gap_wins", 72'(n_win), 72'(4));
        check("gap_fd", 72'(n_fd), 72'(1));
        // Two consecutive random frames
        clear_counts();
        run(32, 0, 1'b0, 1'b0);
        check("f2_wins", 72'(n_win), 72'(8));
        check("f2_fd", 72'(n_fd), 72'(2));
        // Random frame with random gaps
        clear_counts();
        run(16, -1, 1'b0, 1'b0);
        check("rg_wins", 72'(n_win), 72'(4));
        // Reset in the middle of a frame
        run(10, 0, 1'b0, 1'b0);
        do_reset();
        clear_counts();
        run(16, 0, 1'b0, 1'b0);
        check("rr_wins", 72'(n_win), 72'(4));
        check("rr_fd", 72'(n_fd), 72'(1));
        // sof on pixel 6
        run(6, 0, 1'b0, 1'b0);
        clear_counts();
        push(DW'($urandom), 1'b1);
        run(15, 0, 1'b0, 1'b0);
        check("sof_wins", 72'(n_win), 72'(m_win));
        check("sof_fd", 72'(n_fd), 72'(m_fd));
        // Long random run with sporadic sof and gaps
        clear_counts();
        run(64, -1, 1'b0, 1'b1);
        check("rnd_wins", 72'(n_win), 72'(m_win));
        check("rnd_fd", 72'(n_fd), 72'(m_fd));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/median_window_gen.md
MEDIAN_WINDOW_GEN -- requirements
Module: median_window_gen

Interface
REQ-001 Parameter DW, default 8, pixel width in bits.
REQ-002 Parameter IMG_W, default 640, pixels per line (>=3).
REQ-003 Parameter IMG_H, default 480, lines per frame (>=3).
REQ-004 Parameter CW, default 10, column counter width (2^CW >= IMG_W).
REQ-005 Parameter RW, default 9, row counter width (2^RW >= IMG_H).
REQ-006 clk  input  1  single clock; all state updates on the rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 pix_in  input  DW  raster-order pixel.
REQ-009 pix_valid  input  1  pix_in accepted this cycle.
REQ-010 sof  input  1  start-of-frame marker, qualified by pix_valid.
REQ-011 win_out  output  9*DW  3x3 window; tap (i,j) at bits DW*(3*i+j) +: DW, i = row (0 oldest), j = column (0 oldest).
REQ-012 win_valid  output  1  win_out holds a complete interior window.
REQ-013 win_col  output  CW  centre column of the current window.
REQ-014 win_row  output  RW  centre row of the current window.
REQ-015 frame_done  output  1  one-cycle pulse after the last pixel of a frame.

Function
REQ-016 Column counter SHALL increment on each accepted pixel and wrap IMG_W-1 -> 0; row counter SHALL increment on that wrap and wrap IMG_H-1 -> 0.
REQ-017 Cycles with pix_valid=0 SHALL leave all counters, buffers, window registers and state unchanged.
REQ-018 Two line buffers of depth IMG_W SHALL hold lines r-1 and r-2; on an accepted pixel at column c, both reads at c SHALL complete before the writes at c (read-before-write).
REQ-019 Window shift registers SHALL shift one column left per accepted pixel, loading {line r-2 [c], line r-1 [c], pix_in}.
REQ-020 FSM states: IDLE (awaiting first pixel), FILL (rows 0-1), RUN (rows >= 2).
REQ-021 IDLE -> FILL on the first accepted pixel; FILL -> RUN on the row 1 -> 2 wrap; RUN -> FILL on the row IMG_H-1 -> 0 wrap.
REQ-022 win_valid SHALL be registered, asserting one cycle after accepting pixel (r,c) only if state is RUN and c >= 2; win_row = r-1 and win_col = c-1 in that cycle.
REQ-023 Windows SHALL never span lines; columns 0 and 1 of every row SHALL produce no window.
REQ-024 Per frame exactly (IMG_W-2)*(IMG_H-2) windows SHALL be emitted.
REQ-025 frame_done SHALL pulse for one cycle, one cycle after the pixel at (IMG_H-1, IMG_W-1) is accepted, coincident with its win_valid.
REQ-026 win_out, win_row and win_col SHALL hold their last values while win_valid=0.

Reset
REQ-027 On reset assertion, all outputs SHALL be 0 immediately; counters SHALL be 0 and state SHALL be IDLE.
REQ-028 Line buffer contents SHALL not require reset; no stale data SHALL reach a valid window.
REQ-029 Reset asserted mid-frame SHALL abort the frame; the next accepted pixel after release SHALL be treated as (0,0).

Configuration
REQ-030 With MF_SOF_RESYNC_EN defined, an accepted pixel with sof=1 SHALL be taken as (0,0), force state FILL, suppress any window for that cycle, and cause no frame_done.
REQ-031 Without MF_SOF_RESYNC_EN, sof SHALL be ignored and frame framing SHALL derive from the counters alone.

Verification (DW=8, IMG_W=4, IMG_H=4, pixel value = 4*r+c)
REQ-032 Reset, then 16 back-to-back pixels -> 4 windows; first centre (1,1) with win_out taps 0,1,2,4,5,6,8,9,10; frame_done coincident with the 4th window.
REQ-033 Same frame with pix_valid=0 on every other cycle -> identical window sequence, each window one cycle after its completing pixel.
REQ-034 Two consecutive frames -> 8 windows, 2 frame_done pulses, no window at row 0 or row 1 of frame 2.
REQ-035 Reset asserted after pixel 9 and released; then 16 pixels -> outputs 0 during reset, then exactly 4 windows, first centred at (1,1).
REQ-036 MF_SOF_RESYNC_EN defined: sof=1 on pixel 6 of a frame -> that pixel becomes (0,0), no frame_done, 4 windows from the following 16 pixels; without the macro the same stimulus follows counter framing.
